// File: rtl/itch_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : itch_pkg
//  Purpose   : Shared widths, FSM state encoding and ITCH message constants
//              for the ITCH stream framing logic.
//  Revision  : 1.0  initial release
// ============================================================================
package itch_pkg;

  // Output payload width in bits; one message is presented as one word.
  localparam int PAYLOAD_WIDTH = 512;

  // Framing parser states.
  typedef enum logic [1:0] {
    ST_LEN_HI = 2'd0,
    ST_LEN_LO = 2'd1,
    ST_BODY   = 2'd2,
    ST_SKIP   = 2'd3
  } itch_state_e;

  // ASCII message type bytes.
  localparam logic [7:0] ITCH_SYSTEM_EVENT  = 8'h53;
  localparam logic [7:0] ITCH_ADD_ORDER     = 8'h41;
  localparam logic [7:0] ITCH_ADD_ORDER_MPID = 8'h46;
  localparam logic [7:0] ITCH_ORDER_EXEC    = 8'h45;
  localparam logic [7:0] ITCH_ORDER_CANCEL  = 8'h58;
  localparam logic [7:0] ITCH_ORDER_DELETE  = 8'h44;
  localparam logic [7:0] ITCH_ORDER_REPLACE = 8'h55;
  localparam logic [7:0] ITCH_TRADE         = 8'h50;

  // Length of an Add Order message, type byte included.
  localparam logic [15:0] ITCH_LEN_ADD_ORDER = 16'd36;

endpackage : itch_pkg
`default_nettype wire

// File: rtl/itch_msg_assembler.sv
`default_nettype none
// ============================================================================
//  Module    : itch_msg_assembler
//  Purpose   : Frames a length-prefixed ITCH byte stream (2-byte big-endian
//              length per message) into whole messages, presented as one
//              left-justified payload word with type byte and length.
//  Revision  : 1.0  initial release
// ============================================================================
module itch_msg_assembler #(
  parameter int PAYLOAD_WIDTH = itch_pkg::PAYLOAD_WIDTH,
  parameter int MAX_BYTES     = PAYLOAD_WIDTH / 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     byte_valid_i,
  input  logic [7:0]               byte_data_i,
  input  logic                     flush_i,
  output logic                     out_valid_o,
  output logic [7:0]               msg_type_o,
  output logic [PAYLOAD_WIDTH-1:0] payload_o,
  output logic [15:0]              msg_len_o,
  output logic                     len_error_o,
  output logic [15:0]              drop_count_o
);
  import itch_pkg::*;

  localparam logic [1:0] S_LEN_HI = ST_LEN_HI;
  localparam logic [1:0] S_LEN_LO = ST_LEN_LO;
  localparam logic [1:0] S_BODY   = ST_BODY;
  localparam logic [1:0] S_SKIP   = ST_SKIP;

  logic [1:0]               state_q, state_d;
  logic [15:0]              len_q, len_d;
  // Shared counter: body byte index in BODY, bytes left to discard in SKIP.
  logic [15:0]              cnt_q, cnt_d;
  logic [PAYLOAD_WIDTH-1:0] acc_q, acc_d;
  logic [PAYLOAD_WIDTH-1:0] acc_wr;
  logic                     out_valid_q, out_valid_d;
  logic                     len_error_q, len_error_d;
  logic [7:0]               msg_type_q, msg_type_d;
  logic [PAYLOAD_WIDTH-1:0] payload_q, payload_d;
  logic [15:0]              msg_len_q, msg_len_d;
  logic [15:0]              drop_q, drop_d;

  logic                     accept;
  logic [15:0]              len_full;
  logic [MAX_BYTES-1:0]     lane_en;

  // A flush in the same cycle swallows the presented byte.
  assign accept   = byte_valid_i & ~flush_i;
  assign len_full = {len_q[15:8], byte_data_i};

  // Decoded per-lane write enable: body byte i lands in lane i, MSB first.
  for (genvar i = 0; i < MAX_BYTES; i++) begin : g_lane
    assign lane_en[i] = accept && (state_q == S_BODY) && (cnt_q == 16'(i));
    assign acc_wr[PAYLOAD_WIDTH-1-8*i -: 8] =
        lane_en[i] ? byte_data_i : acc_q[PAYLOAD_WIDTH-1-8*i -: 8];
  end

  // Next-state and output decode for the framing parser.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    len_error_d = 1'b0;
    msg_type_d  = msg_type_q;
    payload_d   = payload_q;
    msg_len_d   = msg_len_q;

    if (flush_i) begin
      state_d = S_LEN_HI;
      len_d   = '0;
      cnt_d   = '0;
      acc_d   = '0;
    end else if (byte_valid_i) begin
      case (state_q)
        S_LEN_HI: begin
          len_d   = {byte_data_i, 8'h00};
          state_d = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d = len_full;
          if (len_full == 16'd0) begin
            len_error_d = 1'b1;
            state_d     = S_LEN_HI;
          end else if (len_full > 16'(MAX_BYTES)) begin
            len_error_d = 1'b1;
            cnt_d       = len_full;
            state_d     = S_SKIP;
          end else begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_BODY;
          end
        end
        S_BODY: begin
          acc_d = acc_wr;
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == len_q - 16'd1) begin
            out_valid_d = 1'b1;
            payload_d   = acc_wr;
            msg_type_d  = acc_wr[PAYLOAD_WIDTH-1 -: 8];
            msg_len_d   = len_q;
            state_d     = S_LEN_HI;
          end
        end
        S_SKIP: begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            state_d = S_LEN_HI;
          end
        end
        default: state_d = S_LEN_HI;
      endcase
    end

    drop_d = (len_error_d && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
  end

  // State, accumulator and output registers; reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LEN_HI;
      len_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      len_error_q <= 1'b0;
      msg_type_q  <= '0;
      payload_q   <= '0;
      msg_len_q   <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      len_error_q <= len_error_d;
      msg_type_q  <= msg_type_d;
      payload_q   <= payload_d;
      msg_len_q   <= msg_len_d;
      drop_q      <= drop_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign len_error_o  = len_error_q;
  assign msg_type_o   = msg_type_q;
  assign payload_o    = payload_q;
  assign msg_len_o    = msg_len_q;
  assign drop_count_o = drop_q;

endmodule : itch_msg_assembler
`default_nettype wire

// File: doc/itch_msg_assembler.md
# itch_msg_assembler

Frames a raw ITCH byte stream (2-byte big-endian length prefix per message, MoldUDP64/SoupBinTCP style) into whole messages. Presents each message as one left-justified payload word with its type byte and length. Sits directly upstream of `payload_dispatcher` and drives its `in_valid` / `msg_type` / `payload` inputs one-to-one. No backpressure; accepts one byte per cycle at line rate.

## Interface
- `PAYLOAD_WIDTH`, 512: output payload width in bits; must be a multiple of 8.
- `MAX_BYTES`, PAYLOAD_WIDTH/8: largest message length accepted (64).
- `clk`  in  1  sole clock; all logic rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `byte_valid`  in  1  `byte_data` carries a stream byte this cycle.
- `byte_data`  in  8  stream byte.
- `flush`  in  1  synchronous abort of the current frame; parser returns to `LEN_HI`.
- `out_valid`  out  1  one-cycle pulse: a complete message is on the outputs.
- `msg_type`  out  8  message byte 0 (ASCII type).
- `payload`  out  PAYLOAD_WIDTH  message bytes, left-justified; unused low bytes zero.
- `msg_len`  out  16  message length in bytes, including the type byte.
- `len_error`  out  1  one-cycle pulse: length was 0 or greater than `MAX_BYTES`.
- `drop_count`  out  16  count of rejected frames; saturates at 0xFFFF.

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low (`clk`, `rst_n`).
- FSM states: `LEN_HI`, `LEN_LO`, `BODY`, `SKIP`. Reset state is `LEN_HI`.
- A state advances only on cycles with `byte_valid`=1. Idle cycles hold all state.
- `LEN_HI`: latch `len[15:8]`, go to `LEN_LO`.
- `LEN_LO`: latch `len[7:0]` and evaluate the full length:
  - 0: pulse `len_error`, go to `LEN_HI`.
  - greater than `MAX_BYTES`: pulse `len_error`, load the skip counter with the length, go to `SKIP`.
  - otherwise: clear the accumulator, reset `byte_cnt` to 0, go to `BODY`.
- `BODY`: write byte `i` into `acc[PAYLOAD_WIDTH-1-8*i -: 8]` and increment `byte_cnt`.
  - On byte `i` = len−1: copy the accumulator (including this byte) to `payload`, byte 0 to `msg_type`, and the length to `msg_len`. Pulse `out_valid`. Go to `LEN_HI`.
- `SKIP`: discard bytes, decrement the counter, go to `LEN_HI` after the last discarded byte. No `out_valid`.
- `drop_count` increments on every `len_error` and saturates at 0xFFFF.
- `flush`: takes priority over `byte_valid`; any byte presented in the same cycle is dropped.
  - Returns the FSM to `LEN_HI` and clears the counters and accumulator.
  - Does not pulse `out_valid` or `len_error`.
  - Does not alter the output registers or `drop_count`.
- The accumulator is separate from the output registers, so the next frame can begin the cycle after the last byte.

## Timing
- Reset values: `out_valid`=0, `len_error`=0, `msg_type`=0, `payload`=0, `msg_len`=0, `drop_count`=0. FSM=`LEN_HI`.
- Latency: last body byte accepted at edge N; `out_valid` is high during cycle N+1 (registered output).
- `msg_type`, `payload` and `msg_len` update together with `out_valid` and hold until the next `out_valid`.
- `len_error` is high during the cycle after the `LEN_LO` byte is accepted.
- Throughput: back-to-back frames with no gap. Minimum spacing between `out_valid` pulses is 3 cycles (len=1).
- Reset asserted mid-frame: immediate return to reset values; the partial frame is lost.

## Structure
- Shared package `itch_pkg`:
  - `PAYLOAD_WIDTH`
  - the FSM state enum
  - ASCII type constants (`ITCH_ADD_ORDER` = 8'h41, etc.)
  - `ITCH_LEN_ADD_ORDER` = 36
- Single module, no sub-module. The byte-lane write is a decoded enable per byte of the accumulator.

## Test plan
- Stream 00 24 followed by 36 bytes starting 41 (8'h41): `out_valid` one cycle after the last byte, `msg_type`=8'h41, `msg_len`=36, `payload[511:224]` equals the bytes, `payload[223:0]`=0.
- Two back-to-back frames (len 36 'A', then len 1 type 'D') with no gap: two `out_valid` pulses; the second carries `msg_type`=8'h44, `msg_len`=1, `payload[511:504]`=8'h44, all other bits 0.
- Random `byte_valid` gaps inside the 36-byte frame: identical output to the gapless case; `out_valid` follows the final byte by one cycle.
- Length 00 00 followed by a valid frame, then length 00 64 (100) plus 100 bytes and a valid frame: `len_error` pulses twice, `drop_count`=2, no `out_valid` for the rejected frames, and both valid frames decode correctly.
- `flush` asserted after 10 body bytes, together with a valid byte, then a fresh frame: no output for the aborted frame, the fresh frame decodes correctly, previous `payload` held until then.
- `rst_n` dropped mid-body for 2 cycles, then a fresh frame: all outputs 0 during reset, the fresh frame decodes correctly.
